// File: rtl/fifo_matrix_rx_port.sv
// Fifo matrix rx port: buffers whole frames in a byte RAM, commits legal ones, replays them as AXI-stream.
// Optional frame/drop statistics counters are enabled with FIFO_MATRIX_RX_STATS_EN.
module fifo_matrix_rx_port #(
    parameter int DEPTH           = 4096,
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int MIN_FRAME_BYTES = 14,
    parameter int FRAME_SLOTS     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_matrix_rx_valid,
    output logic       fifo_matrix_rx_ready,
    input  logic [7:0] fifo_matrix_rx_data,
    input  logic       fifo_matrix_rx_last,
    output logic [7:0] tx_axis_tdata,
    output logic       tx_axis_tvalid,
    output logic       tx_axis_tlast,
    input  logic       tx_axis_tready,
    output logic       frame_dropped
`ifdef FIFO_MATRIX_RX_STATS_EN
    ,
    output logic [31:0] rx_frame_count,
    output logic [31:0] rx_drop_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(MAX_FRAME_BYTES + 1);
    localparam int SW = $clog2(FRAME_SLOTS);

    typedef logic [AW:0]   ptr_t;
    typedef logic [LW-1:0] len_t;

    localparam ptr_t        DEPTH_P = ptr_t'(DEPTH);
    localparam ptr_t        MAX_P   = ptr_t'(MAX_FRAME_BYTES);
    localparam len_t        MAX_L   = len_t'(MAX_FRAME_BYTES);
    localparam len_t        MIN_L   = len_t'(MIN_FRAME_BYTES);
    localparam logic [SW:0] SLOTS_C = (SW + 1)'(FRAME_SLOTS);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_DISCARD} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SEND} tx_state_t;

    rx_state_t   rx_state_q, rx_state_d;
    tx_state_t   tx_state_q, tx_state_d;
    ptr_t        wr_ptr_q, wr_ptr_d, wr_start_q, wr_start_d, rd_ptr_q, rd_ptr_d;
    len_t        len_q, len_d, remaining_q, remaining_d;
    logic [SW:0] slot_wr_q, slot_wr_d, slot_rd_q, slot_rd_d;
    logic        ready_q, ready_d, tvalid_q, tvalid_d, tlast_q, tlast_d, drop_q, drop_d;
    logic [7:0]  tdata_q, tdata_d;

    logic [7:0]    ram [DEPTH];
    len_t          slot_mem [FRAME_SLOTS];
    logic [7:0]    ram_rdata_q;
    logic [AW-1:0] rd_addr;
    logic          ram_we, slot_push, slot_pop;
    ptr_t          used, free;
    logic [SW:0]   slot_count;
    len_t          len_inc;

`ifdef FIFO_MATRIX_RX_STATS_EN
    logic [31:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
`endif

    always_comb begin
        rx_state_d  = rx_state_q;
        tx_state_d  = tx_state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_start_d  = wr_start_q;
        rd_ptr_d    = rd_ptr_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        slot_wr_d   = slot_wr_q;
        slot_rd_d   = slot_rd_q;
        ready_d     = 1'b0;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        drop_d      = 1'b0;
        ram_we      = 1'b0;
        slot_push   = 1'b0;
        slot_pop    = 1'b0;
        rd_addr     = rd_ptr_q[AW-1:0] + 1'b1;

        used       = wr_ptr_q - rd_ptr_q;
        free       = DEPTH_P - used;
        slot_count = slot_wr_q - slot_rd_q;
        len_inc    = len_q + 1'b1;

        case (rx_state_q)
            RX_IDLE: begin
                if (fifo_matrix_rx_valid && ready_q) begin
                    wr_start_d = wr_ptr_q;
                    len_d      = '0;
                    rx_state_d = RX_DATA;
                end else begin
                    ready_d = (free >= MAX_P) && (slot_count != SLOTS_C);
                end
            end
            RX_DATA: begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                len_d    = len_inc;
                if (fifo_matrix_rx_last) begin
                    if (len_inc >= MIN_L) begin
                        slot_push = 1'b1;
                    end else begin
                        wr_ptr_d = wr_start_q;
                        drop_d   = 1'b1;
                    end
                    rx_state_d = RX_IDLE;
                end else if (len_inc == MAX_L) begin
                    rx_state_d = RX_DISCARD;
                end
            end
            RX_DISCARD: begin
                if (fifo_matrix_rx_last) begin
                    wr_ptr_d   = wr_start_q;
                    drop_d     = 1'b1;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        // ram_rdata_q always holds the byte after the one on tdata, so a held tready streams one byte per cycle
        case (tx_state_q)
            TX_IDLE: begin
                rd_addr = rd_ptr_q[AW-1:0];
                if (slot_count != '0) begin
                    slot_pop    = 1'b1;
                    remaining_d = slot_mem[slot_rd_q[SW-1:0]];
                    tx_state_d  = TX_LOAD;
                end
            end
            TX_LOAD: begin
                tdata_d    = ram_rdata_q;
                tvalid_d   = 1'b1;
                tlast_d    = (remaining_q == len_t'(1));
                tx_state_d = TX_SEND;
            end
            TX_SEND: begin
                if (tvalid_q && tx_axis_tready) begin
                    rd_ptr_d    = rd_ptr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (tlast_q) begin
                        tvalid_d   = 1'b0;
                        tlast_d    = 1'b0;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tdata_d = ram_rdata_q;
                        tlast_d = (remaining_q == len_t'(2));
                        rd_addr = rd_ptr_q[AW-1:0] + 2'd2;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        if (slot_push) slot_wr_d = slot_wr_q + 1'b1;
        if (slot_pop)  slot_rd_d = slot_rd_q + 1'b1;

`ifdef FIFO_MATRIX_RX_STATS_EN
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (slot_push && frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 1'b1;
        if (drop_d && drop_cnt_q != '1)     drop_cnt_d  = drop_cnt_q + 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q  <= RX_IDLE;
            tx_state_q  <= TX_IDLE;
            wr_ptr_q    <= '0;
            wr_start_q  <= '0;
            rd_ptr_q    <= '0;
            len_q       <= '0;
            remaining_q <= '0;
            slot_wr_q   <= '0;
            slot_rd_q   <= '0;
            ready_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            drop_q      <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            tx_state_q  <= tx_state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_start_q  <= wr_start_d;
            rd_ptr_q    <= rd_ptr_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            slot_wr_q   <= slot_wr_d;
            slot_rd_q   <= slot_rd_d;
            ready_q     <= ready_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            drop_q      <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[wr_ptr_q[AW-1:0]] <= fifo_matrix_rx_data;
        ram_rdata_q <= ram[rd_addr];
        if (slot_push) slot_mem[slot_wr_q[SW-1:0]] <= len_inc;
    end

`ifdef FIFO_MATRIX_RX_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign rx_frame_count = frame_cnt_q;
    assign rx_drop_count  = drop_cnt_q;
`endif

    assign fifo_matrix_rx_ready = ready_q;
    assign tx_axis_tdata        = tdata_q;
    assign tx_axis_tvalid       = tvalid_q;
    assign tx_axis_tlast        = tlast_q;
    assign frame_dropped        = drop_q;
endmodule
